jts16_fd1094_ldr: RTL and testbench

Upstream configuration stage for the FD1094 decryptor. It watches the ROM download stream, extracts the 8 kB FD1094 key region and replays it as the key-RAM write port (prog_addr/prog_data/fd1094_we). It also decides when decryption may be enabled (dec_en). It sits between the download mux and the FD1094 instance in the S16 game module.

---
 rtl/jts16_fd1094_ldr.sv | 174 +++++++++++++++++
 tb/tb_jts16_fd1094_ldr.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/jts16_fd1094_ldr.sv
// FD1094 key loader: snoops the ROM download, replays the key region into key RAM and gates dec_en.
// Optional checksum build: define JTS16_FD1094_CSUM_EN to add key_sum and checksum-qualified key_ok.
module jts16_fd1094_ldr #(
  parameter logic [24:0] KEY_START = 25'h0,
  parameter int          KEY_LEN   = 8192,
  parameter bit          BLANK_DIS = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        downloading,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  input  logic        ioctl_wr,
  input  logic        dec_force,
  output logic [12:0] prog_addr,
  output logic [7:0]  prog_data,
  output logic        fd1094_we,
  output logic        dec_en,
  output logic        key_ok,
  output logic        key_err
`ifdef JTS16_FD1094_CSUM_EN
  ,
  output logic [15:0] key_sum
`endif
);

  typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, CHECK = 2'd2, DONE = 2'd3} state_t;

  localparam logic [13:0] LEN14 = 14'(KEY_LEN);
  localparam logic [24:0] LEN25 = 25'(KEY_LEN);

  state_t      state_r, state_nxt;
  logic        dl_d_r;
  logic        pend_r;
  logic [13:0] cnt_r, cnt_nxt, cnt_base_s;
  logic        nz_r, nz_nxt, nz_base_s;
  logic        key_ok_nxt, key_err_nxt, dec_en_nxt;
  logic        rise_s, fall_s, hit_s, load_entry_s, counting_s, sum_match_s;
  logic [24:0] off_s;

  assign rise_s = downloading & ~dl_d_r;
  assign fall_s = ~downloading & dl_d_r;
  // Unsigned wrap makes addresses below KEY_START fall outside the window
  assign off_s  = ioctl_addr - KEY_START;
  assign hit_s  = ioctl_wr & downloading & (off_s < LEN25);

  // A rise seen during CHECK is remembered in pend_r and taken from DONE
  assign load_entry_s = ((state_r == IDLE) & rise_s) | ((state_r == DONE) & (rise_s | pend_r));
  assign counting_s   = load_entry_s | (state_r == LOAD);

  // FSM state register, edge-detect flop and deferred-rise flag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= IDLE;
      dl_d_r  <= 1'b0;
      pend_r  <= 1'b0;
    end else begin
      state_r <= state_nxt;
      dl_d_r  <= downloading;
      pend_r  <= (state_r == CHECK) & rise_s;
    end
  end

  // FSM next-state decode
  always_comb begin
    state_nxt = state_r;
    case (state_r)
      IDLE:    if (rise_s) state_nxt = LOAD; else state_nxt = IDLE;
      LOAD:    if (fall_s) state_nxt = CHECK; else state_nxt = LOAD;
      CHECK:   state_nxt = DONE;
      DONE:    if (rise_s || pend_r) state_nxt = LOAD; else state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output/datapath decode: byte count, non-zero tracking, verdict and enable
  always_comb begin
    cnt_base_s = load_entry_s ? 14'd0 : cnt_r;
    nz_base_s  = load_entry_s ? 1'b0 : nz_r;
    if (counting_s && hit_s) begin
      if (cnt_base_s != LEN14) cnt_nxt = cnt_base_s + 14'd1;
      else                     cnt_nxt = cnt_base_s;
      nz_nxt = nz_base_s | (ioctl_dout != 8'h00);
    end else begin
      cnt_nxt = cnt_base_s;
      nz_nxt  = nz_base_s;
    end
    key_ok_nxt  = key_ok;
    key_err_nxt = key_err;
    dec_en_nxt  = dec_en;
    if (load_entry_s) begin
      key_ok_nxt  = 1'b0;
      key_err_nxt = 1'b0;
      dec_en_nxt  = 1'b0;
    end else begin
      case (state_r)
        CHECK: begin
          key_ok_nxt  = (cnt_r == LEN14) & sum_match_s;
          key_err_nxt = (cnt_r != 14'd0) & (cnt_r != LEN14);
        end
        DONE:    dec_en_nxt = key_ok & ~dec_force & (nz_r | ~BLANK_DIS);
        default: dec_en_nxt = dec_en;
      endcase
    end
  end

  // Registered status outputs and counters
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_r   <= 14'd0;
      nz_r    <= 1'b0;
      key_ok  <= 1'b0;
      key_err <= 1'b0;
      dec_en  <= 1'b0;
    end else begin
      cnt_r   <= cnt_nxt;
      nz_r    <= nz_nxt;
      key_ok  <= key_ok_nxt;
      key_err <= key_err_nxt;
      dec_en  <= dec_en_nxt;
    end
  end

  // Key RAM write port: one registered write per in-window strobe
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fd1094_we <= 1'b0;
      prog_addr <= 13'd0;
      prog_data <= 8'h00;
    end else begin
      fd1094_we <= hit_s;
      if (hit_s) begin
        prog_addr <= off_s[12:0];
        prog_data <= ioctl_dout;
      end
    end
  end

`ifdef JTS16_FD1094_CSUM_EN
  logic [15:0] pair_r, sum_nxt, pair_nxt, sum_base_s, pair_base_s;

  assign sum_match_s = (key_sum == pair_r);

  // Checksum decode: the final two key bytes form the expected sum, not part of it
  always_comb begin
    sum_base_s  = load_entry_s ? 16'h0000 : key_sum;
    pair_base_s = load_entry_s ? 16'h0000 : pair_r;
    sum_nxt     = sum_base_s;
    pair_nxt    = pair_base_s;
    if (counting_s && hit_s) begin
      if (off_s == 25'(KEY_LEN - 2))      pair_nxt = {ioctl_dout, pair_base_s[7:0]};
      else if (off_s == 25'(KEY_LEN - 1)) pair_nxt = {pair_base_s[15:8], ioctl_dout};
      else                                sum_nxt  = sum_base_s + {8'h00, ioctl_dout};
    end else begin
      sum_nxt  = sum_base_s;
      pair_nxt = pair_base_s;
    end
  end

  // Checksum registers, only advanced while loading
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      key_sum <= 16'h0000;
      pair_r  <= 16'h0000;
    end else begin
      key_sum <= sum_nxt;
      pair_r  <= pair_nxt;
    end
  end
`else
  assign sum_match_s = 1'b1;
`endif

endmodule

// File: tb/tb_jts16_fd1094_ldr.sv
// Directed bench for jts16_fd1094_ldr; a second instance with BLANK_DIS=0 shares all inputs.
module tb_jts16_fd1094_ldr;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        downloading = 1'b0;
  logic [24:0] ioctl_addr = 25'd0;
  logic [7:0]  ioctl_dout = 8'h00;
  logic        ioctl_wr = 1'b0;
  logic        dec_force = 1'b0;

  logic [12:0] prog_addr, b_prog_addr;
  logic [7:0]  prog_data, b_prog_data;
  logic        fd1094_we, b_fd1094_we;
  logic        dec_en, b_dec_en;
  logic        key_ok, b_key_ok;
  logic        key_err, b_key_err;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  jts16_fd1094_ldr #(.KEY_START(25'h40000), .KEY_LEN(8192), .BLANK_DIS(1'b1)) dut (
    .clk(clk), .rst(rst), .downloading(downloading), .ioctl_addr(ioctl_addr),
    .ioctl_dout(ioctl_dout), .ioctl_wr(ioctl_wr), .dec_force(dec_force),
    .prog_addr(prog_addr), .prog_data(prog_data), .fd1094_we(fd1094_we),
    .dec_en(dec_en), .key_ok(key_ok), .key_err(key_err)
  );

  jts16_fd1094_ldr #(.KEY_START(25'h40000), .KEY_LEN(8192), .BLANK_DIS(1'b0)) dut_b (
    .clk(clk), .rst(rst), .downloading(downloading), .ioctl_addr(ioctl_addr),
    .ioctl_dout(ioctl_dout), .ioctl_wr(ioctl_wr), .dec_force(dec_force),
    .prog_addr(b_prog_addr), .prog_data(b_prog_data), .fd1094_we(b_fd1094_we),
    .dec_en(b_dec_en), .key_ok(b_key_ok), .key_err(b_key_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".we"},   {31'd0, fd1094_we}, 32'd0);
    check({tag, ".addr"}, {19'd0, prog_addr}, 32'd0);
    check({tag, ".data"}, {24'd0, prog_data}, 32'd0);
    check({tag, ".en"},   {31'd0, dec_en},    32'd0);
    check({tag, ".ok"},   {31'd0, key_ok},    32'd0);
    check({tag, ".err"},  {31'd0, key_err},   32'd0);
  endtask

  // Raise downloading together with the first strobe and stream n bytes from 'first'
  task automatic load(input logic [24:0] first, input int n, input bit blank);
    logic [24:0] a, off;
    logic [7:0]  d;
    downloading = 1'b1;
    for (int i = 0; i < n; i++) begin
      a = first + 25'(i);
      d = blank ? 8'h00 : (a[7:0] ^ 8'h5A);
      ioctl_addr = a;
      ioctl_dout = d;
      ioctl_wr   = 1'b1;
      tick();
      off = a - 25'h40000;
      if (off < 25'd8192) begin
        check("wr.we",   {31'd0, fd1094_we}, 32'd1);
        check("wr.addr", {19'd0, prog_addr}, {19'd0, off[12:0]});
        check("wr.data", {24'd0, prog_data}, {24'd0, d});
      end else begin
        check("miss.we", {31'd0, fd1094_we}, 32'd0);
      end
    end
    ioctl_wr = 1'b0;
    tick();
    check("gap.we", {31'd0, fd1094_we}, 32'd0);
  endtask

  // Drop downloading and check verdict one cycle after CHECK and enable one cycle later
  task automatic finish_dl(input bit ok, input bit err, input bit en, input bit en_b);
    downloading = 1'b0;
    tick();
    check("chk.ok_pending", {31'd0, key_ok}, 32'd0);
    tick();
    check("end.ok",  {31'd0, key_ok},  {31'd0, ok});
    check("end.err", {31'd0, key_err}, {31'd0, err});
    check("end.en_early", {31'd0, dec_en}, 32'd0);
    tick();
    check("end.en",   {31'd0, dec_en},   {31'd0, en});
    check("end.en_b", {31'd0, b_dec_en}, {31'd0, en_b});
  endtask

  initial begin
    tick();
    tick();
    check_all_zero("rst_hold");
    rst = 1'b1;
    tick();
    check_all_zero("rst_rel");

    // Full key, non-blank
    load(25'h40000, 8192, 1'b0);
    finish_dl(1'b1, 1'b0, 1'b1, 1'b1);

    // OSD override tracks with one cycle of latency
    dec_force = 1'b1;
    check("force.before", {31'd0, dec_en}, 32'd1);
    tick();
    check("force.on", {31'd0, dec_en}, 32'd0);
    dec_force = 1'b0;
    tick();
    check("force.off", {31'd0, dec_en}, 32'd1);

    // Partial key
    load(25'h40000, 4096, 1'b0);
    finish_dl(1'b0, 1'b1, 1'b0, 1'b0);

    // Strobes just outside the window only
    downloading = 1'b1;
    ioctl_addr = 25'h3FFFF; ioctl_dout = 8'h11; ioctl_wr = 1'b1;
    tick();
    check("oow_lo.we", {31'd0, fd1094_we}, 32'd0);
    ioctl_addr = 25'h42000; ioctl_dout = 8'h22;
    tick();
    check("oow_hi.we", {31'd0, fd1094_we}, 32'd0);
    ioctl_wr = 1'b0;
    tick();
    check("oow_gap.we", {31'd0, fd1094_we}, 32'd0);
    finish_dl(1'b0, 1'b0, 1'b0, 1'b0);

    // Blank key: BLANK_DIS=1 keeps dec_en low, BLANK_DIS=0 enables
    load(25'h40000, 8192, 1'b1);
    finish_dl(1'b1, 1'b0, 1'b0, 1'b1);
    check("blank.ok_b", {31'd0, b_key_ok}, 32'd1);

    // Reset in the middle of a load
    load(25'h40000, 100, 1'b0);
    ioctl_addr = 25'h40064; ioctl_dout = 8'h3E; ioctl_wr = 1'b1;
    rst = 1'b0;
    #1;
    check_all_zero("midrst.now");
    tick();
    check_all_zero("midrst.hold");
    ioctl_wr = 1'b0;
    downloading = 1'b0;
    tick();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_all_zero("midrst.after");
    end

    // Complete reload restores the enable
    load(25'h40000, 8192, 1'b0);
    finish_dl(1'b1, 1'b0, 1'b1, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
